tube_hp_fifo_n: RTL

Parametrised host-to-parasite Tube data channel: a dual-clock FIFO written from the host 6502 bus (h_phi2) and read from the parasite bus (p_phi2). It generalises the fixed one/two-byte register FIFOs with configurable width, depth and a programmable parasite-side fill threshold, replacing the V-flag "two bytes available" special case. Overrun and underrun are reported as sticky error flags. One instance serves one Tube register; the top level instantiates one per channel.

---
 rtl/tube_hp_fifo_n_if.sv | 21 ++
 rtl/tube_hp_fifo_n.sv | 121 ++++++++++++
 2 files changed

// File: rtl/tube_hp_fifo_n_if.sv
// Host write / parasite read handshake bundle for one Tube host-to-parasite channel.
interface tube_hp_fifo_n_if #(
  parameter int WIDTH = 8
);
  logic             h_we;
  logic [WIDTH-1:0] h_data;
  logic             h_full;
  logic             p_re;
  logic [WIDTH-1:0] p_data;
  logic             p_data_available;

  modport master (
    output h_we, h_data, p_re,
    input  h_full, p_data, p_data_available
  );

  modport slave (
    input  h_we, h_data, p_re,
    output h_full, p_data, p_data_available
  );
endinterface

// File: rtl/tube_hp_fifo_n.sv
// Dual-clock host-to-parasite Tube FIFO: host writes on negedge h_phi2, parasite pops on
// negedge p_phi2, Gray pointer crossings, programmable fill threshold, sticky error flags.
module tube_hp_fifo_n #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = $clog2(DEPTH) + 1
) (
  input  logic          h_phi2,
  input  logic          p_phi2,
  input  logic          h_rst_b,
  tube_hp_fifo_n_if.slave bus,
  input  logic          h_ovf_clr,
  output logic          h_overflow,
  input  logic [CW-1:0] p_thresh,
  output logic          p_thresh_available,
  output logic [CW-1:0] p_level,
  output logic          p_underflow
);

  function automatic logic [CW-1:0] bin2gray(input logic [CW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
    logic [CW-1:0] b;
    b[CW-1] = g[CW-1];
    for (int i = CW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] wptr, wgray, wptr_nxt;
  logic [CW-1:0] rptr, rgray, rptr_nxt;
  logic [CW-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0] w_sync [SYNC_STAGES];
  logic [CW-1:0] h_count, p_count, eff_thresh;
  logic          h_write, p_pop, p_empty;
  logic          h_tog, tog_seen, tog_arrive;
  logic [SYNC_STAGES-1:0] tog_sync;

  // Host domain
  assign h_count     = wptr - gray2bin(r_sync[SYNC_STAGES-1]);
  assign bus.h_full  = (h_count == CW'(DEPTH));
  assign h_write     = bus.h_we & ~bus.h_full;
  assign wptr_nxt    = wptr + 1'b1;

  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      wptr       <= '0;
      wgray      <= '0;
      h_overflow <= 1'b0;
      h_tog      <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      if (h_write) begin
        wptr  <= wptr_nxt;
        wgray <= bin2gray(wptr_nxt);
      end
      // A write that overflows in the same cycle as the clear keeps the flag set.
      if (bus.h_we && bus.h_full) h_overflow <= 1'b1;
      else if (h_ovf_clr)         h_overflow <= 1'b0;
      if (h_ovf_clr) h_tog <= ~h_tog;
      r_sync[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(negedge h_phi2) begin
    if (h_write) mem[wptr[CW-2:0]] <= bus.h_data;
  end

  // Parasite domain: synchronisers on posedge, pops on negedge
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      for (int i = 0; i < SYNC_STAGES; i++) w_sync[i] <= '0;
      tog_sync <= '0;
    end else begin
      w_sync[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) w_sync[i] <= w_sync[i-1];
      tog_sync <= {tog_sync[SYNC_STAGES-2:0], h_tog};
    end
  end

  assign p_count    = gray2bin(w_sync[SYNC_STAGES-1]) - rptr;
  assign p_empty    = (p_count == '0);
  assign p_pop      = bus.p_re & ~p_empty;
  assign rptr_nxt   = rptr + 1'b1;
  assign tog_arrive = tog_sync[SYNC_STAGES-1] ^ tog_seen;

  always_ff @(negedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      rptr        <= '0;
      rgray       <= '0;
      tog_seen    <= 1'b0;
      p_underflow <= 1'b0;
    end else begin
      if (p_pop) begin
        rptr  <= rptr_nxt;
        rgray <= bin2gray(rptr_nxt);
      end
      tog_seen <= tog_sync[SYNC_STAGES-1];
      if (bus.p_re && p_empty) p_underflow <= 1'b1;
      else if (tog_arrive)     p_underflow <= 1'b0;
    end
  end

  always_comb begin
    eff_thresh = p_thresh;
    if (p_thresh == '0)                eff_thresh = CW'(1);
    else if (p_thresh > CW'(DEPTH))    eff_thresh = CW'(DEPTH);
  end

  assign p_level              = p_count;
  assign bus.p_data_available = ~p_empty;
  assign p_thresh_available   = (p_count >= eff_thresh);
  // Empty reads return all ones, matching unused Tube register bits.
  assign bus.p_data           = p_empty ? {WIDTH{1'b1}} : mem[rptr[CW-2:0]];

endmodule
